// File: rtl/reg_issue_pkg.sv
// Shared issue-stage definitions: datapath widths, the EX operand packet and
// the writeback bypass helper.
package reg_issue_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned UOP_W  = 8;
    localparam int unsigned PC_W   = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [UOP_W-1:0]  uop;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [REG_AW-1:0] rd;
        logic              wen;
    } issue_pkt_t;

    // The register file writes on the clock edge, so a same-cycle writeback
    // must be forwarded over the stale read data. r0 is never forwarded.
    function automatic logic [XLEN-1:0] bypass_operand(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_data,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_addr,
        input logic [XLEN-1:0]   wb_data
    );
        if (wb_en && (wb_addr == addr) && (addr != REG_AW'(0))) begin
            return wb_data;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for in-flight destination writes, with
// effective-busy queries that already account for a same-cycle writeback.
module reg_scoreboard
    import reg_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic              fclr_en_i,
    input  logic [REG_AW-1:0] fclr_addr_i,
    input  logic [REG_AW-1:0] q_rj_i,
    input  logic [REG_AW-1:0] q_rk_i,
    input  logic [REG_AW-1:0] q_rd_i,
    output logic              rj_busy_c_o,
    output logic              rk_busy_c_o,
    output logic              rd_busy_c_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears first, set last: an issuing writer wins over a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (fclr_en_i) begin
            busy_d[fclr_addr_i] = 1'b0;
        end
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rj_busy_c_o = busy_q[q_rj_i] && !(clr_en_i && (clr_addr_i == q_rj_i));
        rk_busy_c_o = busy_q[q_rk_i] && !(clr_en_i && (clr_addr_i == q_rk_i));
        rd_busy_c_o = busy_q[q_rd_i] && !(clr_en_i && (clr_addr_i == q_rd_i));
    end

endmodule

// File: rtl/reg_issue.sv
// Operand-fetch/issue stage: reads sources, stalls on RAW/WAW against the
// scoreboard, forwards same-cycle writeback and registers the packet for EX.
module reg_issue
    import reg_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [UOP_W-1:0]  in_uop,
    input  logic [REG_AW-1:0] in_rj,
    input  logic [REG_AW-1:0] in_rk,
    input  logic              in_use_rj,
    input  logic              in_use_rk,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [UOP_W-1:0]  out_uop,
    output logic [XLEN-1:0]   out_src1,
    output logic [XLEN-1:0]   out_src2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen
);

    issue_pkt_t pkt_q;
    issue_pkt_t pkt_d;
    logic       out_valid_q;
    logic       out_valid_d;

    logic rj_busy_c;
    logic rk_busy_c;
    logic rd_busy_c;
    logic stall_c;
    logic fire_c;
    logic set_en_c;
    logic wb_clr_c;
    logic fl_clr_c;

    assign rf_raddr1 = in_rj;
    assign rf_raddr2 = in_rk;

    reg_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (set_en_c),
        .set_addr_i  (in_rd),
        .clr_en_i    (wb_clr_c),
        .clr_addr_i  (wb_addr),
        .fclr_en_i   (fl_clr_c),
        .fclr_addr_i (pkt_q.rd),
        .q_rj_i      (in_rj),
        .q_rk_i      (in_rk),
        .q_rd_i      (in_rd),
        .rj_busy_c_o (rj_busy_c),
        .rk_busy_c_o (rk_busy_c),
        .rd_busy_c_o (rd_busy_c)
    );

    always_comb begin
        stall_c  = (in_use_rj && rj_busy_c) || (in_use_rk && rk_busy_c)
                || (in_wen && rd_busy_c);
        in_ready = !stall_c && !flush && (!out_valid_q || out_ready);
        fire_c   = in_valid && in_ready;
        set_en_c = fire_c && in_wen && (in_rd != REG_AW'(0));
        wb_clr_c = wb_en && (wb_addr != REG_AW'(0));
        // A flushed packet never reaches writeback, so release its destination.
        fl_clr_c = flush && out_valid_q && pkt_q.wen && (pkt_q.rd != REG_AW'(0));
    end

    always_comb begin
        pkt_d       = pkt_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire_c) begin
            out_valid_d = 1'b1;
            pkt_d.pc    = in_pc;
            pkt_d.uop   = in_uop;
            pkt_d.src1  = bypass_operand(in_rj, rf_rdata1, wb_en, wb_addr, wb_data);
            pkt_d.src2  = bypass_operand(in_rk, rf_rdata2, wb_en, wb_addr, wb_data);
            pkt_d.rd    = in_rd;
            pkt_d.wen   = in_wen;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pkt_q       <= pkt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = pkt_q.pc;
    assign out_uop   = pkt_q.uop;
    assign out_src1  = pkt_q.src1;
    assign out_src2  = pkt_q.src2;
    assign out_rd    = pkt_q.rd;
    assign out_wen   = pkt_q.wen;

endmodule

// File: tb/tb_reg_issue.sv
// Directed-vector bench for reg_issue: one table row per clock cycle, plus an
// asynchronous reset sequence with a packet in flight.
module tb_reg_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [7:0]  in_uop;
    logic [4:0]  in_rj;
    logic [4:0]  in_rk;
    logic        in_use_rj;
    logic        in_use_rk;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [7:0]  out_uop;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [4:0]  out_rd;
    logic        out_wen;

    reg_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_uop    (in_uop),
        .in_rj     (in_rj),
        .in_rk     (in_rk),
        .in_use_rj (in_use_rj),
        .in_use_rk (in_use_rk),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_uop   (out_uop),
        .out_src1  (out_src1),
        .out_src2  (out_src2),
        .out_rd    (out_rd),
        .out_wen   (out_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rj;
        logic        urj;
        logic [4:0]  rk;
        logic        urk;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        fl;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_s1;
        logic [31:0] e_s2;
        logic [4:0]  e_rd;
        logic        e_wen;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_pc;
    logic [7:0]  exp_uop;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rj, input logic urj,
        input logic [4:0] rk, input logic urk, input logic [4:0] rd, input logic wen,
        input logic [31:0] rf1, input logic [31:0] rf2,
        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
        input logic fl, input logic ordy,
        input logic e_rdy, input logic e_ov, input logic [31:0] e_s1,
        input logic [31:0] e_s2, input logic [4:0] e_rd, input logic e_wen
    );
        vec_t r;
        r.v = v; r.rj = rj; r.urj = urj; r.rk = rk; r.urk = urk; r.rd = rd;
        r.wen = wen; r.rf1 = rf1; r.rf2 = rf2; r.wbe = wbe; r.wba = wba;
        r.wbd = wbd; r.fl = fl; r.ordy = ordy; r.e_rdy = e_rdy; r.e_ov = e_ov;
        r.e_s1 = e_s1; r.e_s2 = e_s2; r.e_rd = e_rd; r.e_wen = e_wen;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t, input int idx);
        in_valid  = t.v;
        in_pc     = 32'h1000 + 32'(idx) * 32'd4;
        in_uop    = 8'(idx);
        in_rj     = t.rj;
        in_use_rj = t.urj;
        in_rk     = t.rk;
        in_use_rk = t.urk;
        in_rd     = t.rd;
        in_wen    = t.wen;
        rf_rdata1 = t.rf1;
        rf_rdata2 = t.rf2;
        wb_en     = t.wbe;
        wb_addr   = t.wba;
        wb_data   = t.wbd;
        flush     = t.fl;
        out_ready = t.ordy;
    endtask

    // Drive at the falling edge, check in_ready before the rising edge and the
    // registered packet just after it.
    task automatic step(input vec_t t, input int idx);
        drive(t, idx);
        #1;
        chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(t.e_rdy));
        chk($sformatf("v%0d rf_raddr1", idx), 32'(rf_raddr1), 32'(t.rj));
        if (t.v && t.e_rdy) begin
            exp_pc  = in_pc;
            exp_uop = in_uop;
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(t.e_ov));
        if (t.e_ov) begin
            chk($sformatf("v%0d out_src1", idx), out_src1, t.e_s1);
            chk($sformatf("v%0d out_src2", idx), out_src2, t.e_s2);
            chk($sformatf("v%0d out_rd", idx), 32'(out_rd), 32'(t.e_rd));
            chk($sformatf("v%0d out_wen", idx), 32'(out_wen), 32'(t.e_wen));
            chk($sformatf("v%0d out_pc", idx), out_pc, exp_pc);
            chk($sformatf("v%0d out_uop", idx), 32'(out_uop), 32'(exp_uop));
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_pc  = '0;
        exp_uop = '0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0), 0);
        rst = 1'b0;

        // Columns: v rj urj rk urk rd wen rf1 rf2 wbe wba wbd fl ordy | rdy ov s1 s2 rd wen
        vecs.push_back(mk(1,0,0,0,0,1,1,'h11,'h12,0,0,0,0,1, 1,1,'h11,'h12,1,1));
        vecs.push_back(mk(1,0,0,0,0,2,1,'h21,'h22,0,0,0,0,1, 1,1,'h21,'h22,2,1));
        vecs.push_back(mk(1,0,0,0,0,5,1,'h31,'h32,0,0,0,0,1, 1,1,'h31,'h32,5,1));
        vecs.push_back(mk(1,5,1,0,0,6,1,'h41,'h42,0,0,0,0,1, 0,0,0,0,0,0));
        vecs.push_back(mk(1,5,1,0,0,6,1,'h41,'h42,1,5,'hDEADBEEF,0,1, 1,1,'hDEADBEEF,'h42,6,1));
        vecs.push_back(mk(1,5,1,0,0,0,0,'hDEADBEEF,'h52,0,0,0,0,1, 1,1,'hDEADBEEF,'h52,0,0));
        vecs.push_back(mk(1,0,0,0,0,7,1,'h61,'h62,0,0,0,0,1, 1,1,'h61,'h62,7,1));
        vecs.push_back(mk(1,0,0,0,0,7,1,'h71,'h72,0,0,0,0,1, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,7,1,'h71,'h72,1,7,'h77,0,1, 1,1,'h71,'h72,7,1));
        vecs.push_back(mk(1,0,0,7,1,0,0,'h91,'h92,0,0,0,0,1, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,7,1,0,0,'h91,'h92,1,7,'h77,0,1, 1,1,'h91,'h77,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,'hB1,'hB2,0,0,0,0,1, 1,1,'hB1,'hB2,0,1));
        vecs.push_back(mk(1,0,1,0,1,0,1,0,0,1,0,'h1234,0,1, 1,1,0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,8,1,'hD1,'hD2,0,0,0,0,1, 1,1,'hD1,'hD2,8,1));
        vecs.push_back(mk(1,0,0,0,0,3,1,'hE1,'hE2,0,0,0,0,0, 0,1,'hD1,'hD2,8,1));
        vecs.push_back(mk(1,0,0,0,0,3,1,'hE1,'hE2,0,0,0,0,0, 0,1,'hD1,'hD2,8,1));
        vecs.push_back(mk(1,0,0,0,0,3,1,'hE1,'hE2,0,0,0,0,0, 0,1,'hD1,'hD2,8,1));
        vecs.push_back(mk(1,0,0,0,0,3,1,'hE1,'hE2,0,0,0,0,1, 1,1,'hE1,'hE2,3,1));
        vecs.push_back(mk(1,0,0,0,0,9,1,'hF1,'hF2,0,0,0,0,1, 1,1,'hF1,'hF2,9,1));
        vecs.push_back(mk(1,9,1,0,0,0,0,'h101,'h102,0,0,0,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,9,1,0,0,0,0,'h101,'h102,0,0,0,0,1, 1,1,'h101,'h102,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,'h1,'h2,0,0,0,0,1, 0,0,0,0,0,0));

        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_pc", out_pc, 32'd0);
        chk("reset out_src1", out_src1, 32'd0);
        chk("reset out_rd", 32'(out_rd), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Asynchronous reset with a packet held under backpressure.
        drive(mk(1,0,0,0,0,10,1,'hAA,'hBB,0,0,0,0,0, 0,0,0,0,0,0), 40);
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        chk("pre-reset out_rd", 32'(out_rd), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset out_rd", 32'(out_rd), 32'd0);
        in_valid  = 1'b1;
        in_rj     = 5'd1;
        in_use_rj = 1'b1;
        in_wen    = 1'b0;
        #1;
        chk("async reset busy cleared", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_issue.md
# reg_issue

Operand-fetch/issue stage directly upstream of the register file in the LA32R pipeline. It accepts one decoded instruction per cycle and reads the source operands through the two register-file read ports. It tracks in-flight destination writes in a 32-entry busy scoreboard, stalls on RAW/WAW hazards, and bypasses same-cycle writeback data. It then presents a registered operand packet to EX over a valid/ready handshake.

## Interface
- XLEN, 32: data width
- UOP_W, 8: width of the opaque decoded-op field passed through
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle
- in_pc  in  32  instruction PC
- in_uop  in  UOP_W  decoded op, passed through
- in_rj, in_rk  in  5  source register addresses
- in_use_rj, in_use_rk  in  1  source is actually read
- in_rd  in  5  destination address
- in_wen  in  1  instruction writes in_rd
- rf_raddr1, rf_raddr2  out  5  to register-file read ports 1/2 (= in_rj, in_rk, combinational)
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data (combinational; r0 reads 0)
- wb_en, wb_addr[5], wb_data[XLEN]  in  same signals that drive the register-file write port
- flush  in  1  redirect from EX; kills younger work
- out_valid  out  1  packet valid
- out_ready  in  1  EX accepts packet
- out_pc[32], out_uop[UOP_W], out_src1[XLEN], out_src2[XLEN], out_rd[5], out_wen  out  registered packet

## Operation
- Scoreboard: busy[31:0]; busy[0] constant 0.
- Set: on fire (in_valid && in_ready) with in_wen && in_rd!=0 → busy[in_rd]=1.
- Clear: on wb_en && wb_addr!=0 → busy[wb_addr]=0.
- Set and clear of the same address in one cycle: set wins.
- Bypass: src1 = (wb_en && wb_addr==in_rj && in_rj!=0) ? wb_data : rf_rdata1; src2 is the same with in_rk/rf_rdata2. Needed because the register file writes synchronously.
- Effective busy of a source s: busy[s] && !(wb_en && wb_addr==s).
- Stall when:
  - in_use_rj and rj is effectively busy (RAW), or
  - in_use_rk and rk is effectively busy (RAW), or
  - in_wen and rd is effectively busy (WAW).
- Unused sources never stall; their operand value is don't-care but still captured.
- in_ready = !stall && !flush && (!out_valid || out_ready).
- Output register:
  - Loads the packet on fire.
  - Else clears out_valid on out_ready.
  - Holds all fields stable while out_valid && !out_ready.
- Flush:
  - out_valid←0; no fire that cycle.
  - If out_valid && out_wen && out_rd!=0, busy[out_rd]←0, unless a wb clear/set rule already targets it; the clear has no conflicting set because there is no fire.
  - Flush originates in EX, so younger instructions exist only in the output register and the input.
- Reset: busy=0, out_valid=0, all out_* fields=0; in_ready follows the combinational equation.

## Timing
- Latency: input fire in cycle N → out_valid with operands in cycle N+1.
- Throughput 1/cycle with no hazards and out_ready held high.
- Operands in the output register are final. Their sources were non-busy at capture, so no later forwarding is required.
- A stalled consumer of rd issues in the same cycle that the producer's wb_en appears (bypassed value).
- in_valid may drop without having fired; the stage holds no input state.
- Reset mid-operation discards the output packet and the scoreboard immediately (asynchronous).

## Structure
- Shared package (existing CPU package): XLEN, NREG=32, REG_AW=5, and a typedef issue_pkt_t {pc, uop, src1, src2, rd, wen} used for the output register and EX input.
- Sub-module reg_scoreboard holds:
  - the busy vector with set/clear/flush-clear ports;
  - three combinational query ports (rj, rk, rd) returning effective busy.
- Top level connects rf_* to regfile_port read instances.

## Test plan
- Reset → out_valid=0, busy=0. Independent ops r1←, r2← issue back-to-back with out_ready=1 → out_valid every cycle, one-cycle latency.
- RAW bypass:
  - Issue writer to r5, then reader of r5 → reader stalls (in_ready=0).
  - wb_en=1, wb_addr=5, wb_data=0xDEADBEEF → reader fires that cycle; next cycle out_src1=0xDEADBEEF and busy[5]=1 only if the reader writes r5.
- WAW: r7 busy, new instruction with in_wen, rd=7 and no sources → stalls until wb to r7, then issues and busy[7]=1 (set wins over same-cycle clear).
- r0:
  - Writer with rd=0 leaves busy=0.
  - Reader of r0 with wb_en=1, wb_addr=0, wb_data=0x1234 → out_src1=0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_* stable, in_ready=0; out_ready=1 → next packet loads the same cycle.
- Flush with packet rd=9 in the output register → out_valid=0 next cycle, busy[9]=0; an input reading r9 then issues without stall.
